ftoi_arbiter: RTL and testbench
===============================

# ftoi_arbiter

Round-robin arbiter that shares one `ftoi` float-to-int conversion unit among `NREQ` requesters, such as issue ports or a vector lane group. Each requester offers a 32-bit IEEE-754 single. One request is granted per cycle. The result returns one cycle later, tagged with the requester index. The block sits between the issue stage and the shared converter, so per-port `ftoi` copies are not needed.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `IDW`, default `$clog2(NREQ)`: width of the requester id.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `hold  in  1`: when high, no new grants; in-flight work still completes.
- `req_valid  in  NREQ`: requester i has an operand.
- `req_x  in  32*NREQ`: operand of requester i, in bits `[32*i +: 32]`.
- `req_ready  out  NREQ`: one-hot grant; transfer from requester i when `req_valid[i] & req_ready[i]`.
- `resp_valid  out  1`: result present this cycle. No backpressure.
- `resp_id  out  IDW`: index of the requester that owns `resp_y`.
- `resp_y  out  32`: converted signed integer.
- `issued_cnt  out  32`: count of accepted requests, wraps at 2^32.

## Operation
- `req_ready` is combinational from `req_valid`, `hold`, `rst` and the priority pointer `ptr`.
  - When `rst` or `hold` is high, `req_ready` = 0.
  - Otherwise the grant goes to the first set `req_valid[k]`, searching k = ptr, ptr+1, … modulo NREQ.
  - `req_ready` is never asserted for an idle requester.
- At most one grant per cycle.
- On a grant to index g:
  - The mux steers `req_x[g]` into the `ftoi` input.
  - `ptr` <= (g+1) mod NREQ. Wrap happens at NREQ, not at 2^IDW, when NREQ is not a power of two.
  - `issued_cnt` increments by 1.
- With no grant, `ptr` holds.
- Conversion semantics are those of `ftoi`, with no saturation:
  - Truncation toward zero.
  - Exponent ≤ 126 (magnitude < 1.0, including ±0 and denormals) gives 0.
  - Negative inputs give two's complement.
  - Exponent > 158 (out of range, including Inf/NaN) gives an unspecified value. Callers must not rely on it.
- Tag pipeline: a registered `{valid, id}` stage runs in parallel with the `ftoi` output register.
  - `resp_valid` <= grant_any.
  - `resp_id` <= g.
- When no grant occurs, the `ftoi` input is driven to 0 (not to the previous requester's data), so `resp_y` is deterministic.
- The requester must hold `req_valid` and `req_x` stable until accepted. The arbiter may change its grant choice between cycles only if a higher-priority requester appears.

## Timing
- Latency is 1: a request accepted in cycle t has `resp_valid`, `resp_id` and `resp_y` valid in cycle t+1.
- Throughput is 1 conversion per cycle, back-to-back with no bubbles.
- Reset values:
  - `resp_valid` = 0, `resp_id` = 0, `issued_cnt` = 0, `ptr` = 0.
  - `resp_y` has no reset (the `ftoi` register is unreset). It is unspecified until the first `resp_valid`, so checkers qualify it with `resp_valid`.
- Reset mid-operation:
  - A request granted in cycle t, with `rst` asserted only from cycle t+1, still responds in t+1.
  - Any cycle with `rst` high grants nothing, so `resp_valid` is 0 in the following cycle.
- When `hold` rises in cycle t, a grant made in t-1 still responds in t, and no grant occurs in t.
- Simultaneous requests from all ports are served in strict rotation from `ptr`. Worst-case wait is NREQ-1 cycles when `hold` is low.

## Structure
- Shared package `fpu_pkg`:
  - `FTOI_LAT` = 1.
  - Float field widths: sign 1, exponent 8, mantissa 23.
  - `FTOI_ZERO_EXP` = 126.
- Sub-module `rr_arbiter #(N)` (combinational priority pick from `ptr`, plus the registered pointer update) is natural and reusable by a later `itof` sharing block.
- Instantiates the existing `ftoi` unit unchanged.
- The tag pipeline depth is derived from `FTOI_LAT`.

## Test plan
- Single request: req0 with `0x40490FDB` (3.14159) in cycle t → `resp_valid`=1, `resp_id`=0, `resp_y`=3 in t+1; `issued_cnt`=1.
- Signs and small values:
  - `0xC0490FDB` → `0xFFFFFFFD`.
  - `0x3F000000` (0.5) → 0.
  - `0xBF800000` (−1.0) → `0xFFFFFFFF`.
  - `0x40200000` (2.5) → 2.
- All 4 valid continuously from reset with distinct operands:
  - Grants go 0,1,2,3,0,… one per cycle.
  - `resp_id` follows the same order, one cycle later.
  - `issued_cnt` = 8 after 8 cycles.
- NREQ=3 build: requesters 1 and 2 valid, `ptr` at 2 → grant order 2,1,2,1; the pointer never reaches 3.
- `hold` high for 3 cycles with all requesters valid → `req_ready`=0 during those cycles; `resp_valid` drops the cycle after the first hold cycle; rotation resumes from the saved `ptr`.
- `rst` pulsed for 1 cycle one cycle after a grant → that grant's response still appears; the next cycle has `resp_valid`=0; `issued_cnt` and `ptr` = 0; the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared floating-point constants and field layout used by the conversion
// units and by the blocks that share them.
package fpu_pkg;
    localparam int FTOI_LAT      = 1;
    localparam int SIGN_W        = 1;
    localparam int EXP_W         = 8;
    localparam int MANT_W        = 23;
    localparam int EXP_BIAS      = 127;
    localparam int FTOI_ZERO_EXP = 126;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float_t;
endpackage

// File: rtl/ftoi.sv
// Single-precision float to signed 32-bit integer, truncating toward zero.
// One register stage; the output register has no reset.
module ftoi
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] x,
    output logic [31:0] y
);
    localparam logic [EXP_W-1:0] ZERO_EXP = EXP_W'(FTOI_ZERO_EXP);
    localparam logic [EXP_W-1:0] INT_EXP  = EXP_W'(EXP_BIAS + MANT_W);

    float_t      f;
    logic [31:0] sig;
    logic [31:0] mag;
    logic [31:0] y_d;
    logic [31:0] y_q;

    assign f = float_t'(x);

    // INT_EXP is the exponent at which the mantissa LSB has weight 1.
    always_comb begin
        sig = {{(32-MANT_W-1){1'b0}}, 1'b1, f.mant};
        mag = '0;
        if (f.exp > ZERO_EXP) begin
            if (f.exp >= INT_EXP) begin
                mag = sig << (f.exp - INT_EXP);
            end else begin
                mag = sig >> (INT_EXP - f.exp);
            end
        end
        y_d = (f.sign != '0) ? (~mag + 32'd1) : mag;
    end

    always_ff @(posedge clk) begin
        y_q <= y_d;
    end

    assign y = y_q;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot pick starting at a registered priority pointer; the
// pointer moves to one past the winner and wraps at N.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_any
);
    localparam logic [IDW:0]   N_W  = (IDW+1)'(N);
    localparam logic [IDW-1:0] LAST = IDW'(N-1);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW:0]   cand;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (en && !gnt_any && req[cand[IDW-1:0]]) begin
                gnt[cand[IDW-1:0]] = 1'b1;
                gnt_id             = cand[IDW-1:0];
                gnt_any            = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_id == LAST) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/ftoi_arbiter.sv
// Shares one ftoi converter among NREQ requesters with round-robin grants;
// results come back FTOI_LAT cycles later tagged with the requester id.
module ftoi_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_y,
    output logic [31:0]          issued_cnt
);
    logic [31:0]    x_arr [NREQ];
    logic           grant_any;
    logic [IDW-1:0] grant_id;
    logic [31:0]    ftoi_x;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[32*gi +: 32];
        end
    endgenerate

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (!rst && !hold),
        .req     (req_valid),
        .gnt     (req_ready),
        .gnt_id  (grant_id),
        .gnt_any (grant_any)
    );

    // Idle cycles feed zero so resp_y never echoes stale operand data.
    assign ftoi_x = grant_any ? x_arr[grant_id] : '0;

    ftoi u_ftoi (
        .clk (clk),
        .x   (ftoi_x),
        .y   (resp_y)
    );

    logic [FTOI_LAT-1:0] tag_v_q;
    logic [FTOI_LAT-1:0] tag_v_d;
    logic [IDW-1:0]      tag_id_q [FTOI_LAT];
    logic [IDW-1:0]      tag_id_d [FTOI_LAT];
    logic [31:0]         cnt_q;
    logic [31:0]         cnt_d;

    always_comb begin
        tag_v_d     = '0;
        tag_v_d[0]  = grant_any;
        tag_id_d[0] = grant_id;
        for (int s = 1; s < FTOI_LAT; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end
        cnt_d = grant_any ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q <= '0;
            cnt_q   <= '0;
            for (int s = 0; s < FTOI_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            cnt_q    <= cnt_d;
        end
    end

    assign resp_valid = tag_v_q[FTOI_LAT-1];
    assign resp_id    = tag_id_q[FTOI_LAT-1];
    assign issued_cnt = cnt_q;
endmodule

// File: tb/tb_ftoi_arbiter.sv
// Bench for ftoi_arbiter: a 4-port instance checked cycle by cycle against a
// reference model and response queue, plus a 3-port instance for wrap order.
module tb_ftoi_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         hold;
    logic [3:0]   req_valid;
    logic [127:0] req_x;
    logic [3:0]   req_ready;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [31:0]  resp_y;
    logic [31:0]  issued_cnt;

    logic         rst3;
    logic         hold3;
    logic [2:0]   v3;
    logic [95:0]  x3;
    logic [2:0]   rdy3;
    logic         rv3;
    logic [1:0]   rid3;
    logic [31:0]  y3;
    logic [31:0]  cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ftoi_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_x(req_x),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_y(resp_y), .issued_cnt(issued_cnt)
    );

    ftoi_arbiter #(.NREQ(3)) dut3 (
        .clk(clk), .rst(rst3), .hold(hold3), .req_valid(v3), .req_x(x3),
        .req_ready(rdy3), .resp_valid(rv3), .resp_id(rid3),
        .resp_y(y3), .issued_cnt(cnt3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference conversion: scale the full significand in 64 bits, then drop fraction.
    function automatic logic [31:0] f2i(input logic [31:0] b);
        int          e;
        longint      m;
        logic [31:0] r;
        e = int'(b[30:23]);
        if (e < 127) return 32'd0;
        m = longint'({1'b1, b[22:0]}) << (e - 127);
        m = m >> 23;
        r = m[31:0];
        if (b[31]) r = -r;
        return r;
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0] e;
        e = 8'($urandom_range(100, 158));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    typedef struct {
        int          id;
        logic [31:0] y;
    } exp_t;

    exp_t        sb_q[$];
    int          ptr_m = 0;
    logic [31:0] cnt_m = 0;

    always @(negedge clk) begin : monitor
        exp_t       e;
        int         g;
        logic [3:0] exp_rdy;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("resp_valid", {31'b0, resp_valid}, 32'd1);
            check_eq("resp_id", {30'b0, resp_id}, 32'(e.id));
            check_eq("resp_y", resp_y, e.y);
        end else begin
            check_eq("resp_idle", {31'b0, resp_valid}, 32'd0);
        end
        check_eq("issued_cnt", issued_cnt, cnt_m);
        g = (rst || hold) ? -1 : pick(req_valid, ptr_m);
        exp_rdy = (g < 0) ? 4'd0 : 4'(1 << g);
        check_eq("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
        if (rst) begin
            ptr_m = 0;
            cnt_m = 0;
        end else if (g >= 0) begin
            sb_q.push_back('{g, f2i(req_x[32*g +: 32])});
            ptr_m = (g + 1) % 4;
            cnt_m = cnt_m + 32'd1;
        end
    end

    task automatic send_one(input int i, input logic [31:0] x, input logic [31:0] ey);
        req_valid        = 4'(1 << i);
        req_x[32*i +: 32] = x;
        cycle();
        req_valid = 4'd0;
        @(negedge clk);
        check_eq("dir_y", resp_y, ey);
        check_eq("dir_id", {30'b0, resp_id}, 32'(i));
        cycle();
    endtask

    int          g3_exp [8] = '{1, 2, 1, 2, 1, 2, 0, 1};
    logic [31:0] y3_lane [3] = '{32'd3, 32'd1, 32'd2};
    logic [3:0]  acc;

    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = '0; req_x = '0;
        rst3 = 1'b1; hold3 = 1'b0; v3 = '0; x3 = '0;
        cycle();
        cycle();
        check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("rst_resp_id", {30'b0, resp_id}, 32'd0);
        check_eq("rst_issued", issued_cnt, 32'd0);
        rst = 1'b0;

        send_one(0, 32'h40490FDB, 32'd3);
        check_eq("single_cnt", issued_cnt, 32'd1);
        send_one(1, 32'hC0490FDB, 32'hFFFFFFFD);
        send_one(2, 32'h3F000000, 32'h00000000);
        send_one(3, 32'hBF800000, 32'hFFFFFFFF);
        send_one(0, 32'h40200000, 32'd2);

        // Full rotation from a fresh reset with every port requesting.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_x = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("rot_gnt", {28'b0, req_ready}, 32'(1 << (k % 4)));
            if (k > 0) check_eq("rot_id", {30'b0, resp_id}, 32'((k - 1) % 4));
            cycle();
        end
        check_eq("rot_cnt8", issued_cnt, 32'd8);

        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("hold_rdy", {28'b0, req_ready}, 32'd0);
            cycle();
        end
        hold = 1'b0;
        @(negedge clk);
        check_eq("hold_resume", {28'b0, req_ready}, 32'd1);
        cycle();
        cycle();

        // Reset one cycle after the grant to port 1.
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_inflight_v", {31'b0, resp_valid}, 32'd1);
        check_eq("rst_inflight_id", {30'b0, resp_id}, 32'd1);
        check_eq("rst_rdy", {28'b0, req_ready}, 32'd0);
        cycle();
        rst = 1'b0;
        req_valid = 4'b0110;
        @(negedge clk);
        check_eq("post_rst_v", {31'b0, resp_valid}, 32'd0);
        check_eq("post_rst_cnt", issued_cnt, 32'd0);
        check_eq("post_rst_gnt", {28'b0, req_ready}, 32'd2);
        cycle();
        cycle();

        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i]      = 1'($urandom_range(0, 1));
                    req_x[32*i +: 32] = rand_float();
                end
            end
            hold = ($urandom_range(0, 5) == 0);
        end
        req_valid = '0;
        hold = 1'b0;
        cycle();
        cycle();

        // Three-port instance: wrap must go 2 -> 0, never through index 3.
        rst3 = 1'b0;
        x3 = {32'h40000000, 32'h3F800000, 32'h40400000};
        v3 = 3'b110;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) v3 = 3'b111;
            @(negedge clk);
            check_eq("n3_gnt", {29'b0, rdy3}, 32'(1 << g3_exp[c]));
            if (c > 0) begin
                check_eq("n3_rv", {31'b0, rv3}, 32'd1);
                check_eq("n3_id", {30'b0, rid3}, 32'(g3_exp[c-1]));
                check_eq("n3_y", y3, y3_lane[g3_exp[c-1]]);
            end
            cycle();
        end
        v3 = '0;
        @(negedge clk);
        check_eq("n3_last_id", {30'b0, rid3}, 32'(g3_exp[7]));
        check_eq("n3_cnt", cnt3, 32'd8);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
